multi_alarm_ctrl: RTL and testbench
===================================

// Module: multi_alarm_ctrl
// PURPOSE
//  N-channel alarm controller for the digital clock. Holds N programmable HH:MM alarm slots.
//  Compares each slot against the running BCD time and drives per-channel ringing, snooze and
//  missed status plus a blinking alarm LED. Sits beside the timekeeping counter; the button
//  debouncers drive the program, dismiss and snooze pulses.
// PARAMETERS
//  N_ALARMS     4   number of alarm channels (1..8)
//  SNOOZE_MIN   5   snooze duration in minutes (1..59); reload = SNOOZE_MIN*60 ticks
//  SNOOZE_MAX   3   snoozes allowed per ring event; a further snooze acts as dismiss
//  RING_TO_S    60  ring timeout in ticks before auto-stop (1..255)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      reset, asynchronous, active-high
//  tick_1hz   in   1      one-clk pulse per second, synchronous to clk
//  cur_time   in   16     BCD {hour_tens,hour_units,min_tens,min_units}
//  cur_sec    in   8      BCD {sec_tens,sec_units}
//  alarm_en   in   1      global enable; 0 forces all channels IDLE
//  wr_en      in   1      one-clk pulse: program slot wr_idx
//  wr_idx     in   IW     slot index, IW = max(1,$clog2(N_ALARMS))
//  wr_time    in   16     BCD HH:MM to store
//  wr_arm     in   1      arm bit stored with the slot
//  dismiss    in   1      one-clk pulse: stop all ringing/snoozed channels
//  snooze     in   1      one-clk pulse: snooze all ringing channels
//  missed_clr in   1      one-clk pulse: clear all missed flags
//  rd_idx     in   IW     readback index
//  rd_time    out  16     stored time of slot rd_idx (combinational)
//  rd_arm     out  1      arm bit of slot rd_idx (combinational)
//  ringing    out  N      per-channel RINGING
//  snoozed    out  N      per-channel SNOOZED
//  missed     out  N      sticky: channel timed out unanswered
//  any_ring   out  1      |ringing
//  ring_idx   out  IW     lowest-index ringing channel, 0 when none
//  alarm_led  out  1      blinks at 0.5 Hz while any_ring, else 0
// BEHAVIOUR
//  Reset: all slots 16'h0000, arm 0; all channels IDLE; snooze/ring/use counters 0; missed 0;
//   alarm_led 0.
//  Per channel FSM: IDLE, RINGING, SNOOZED.
//   IDLE->RINGING: tick_1hz & arm & alarm_en & cur_time==slot & cur_sec==8'h00.
//    The match fires once per minute only, and only on the tick. The ring counter and the
//    snooze-use counter clear to 0.
//   RINGING: the ring counter increments on each tick.
//    On reaching RING_TO_S the channel goes to IDLE and sets missed.
//   RINGING+snooze: if uses<SNOOZE_MAX, go to SNOOZED, uses+1, load snooze counter with
//    SNOOZE_MIN*60. Otherwise go to IDLE, as for a dismiss.
//   SNOOZED: the counter decrements on tick. When it reaches 0, go to RINGING and clear the ring
//    counter.
//   RINGING/SNOOZED+dismiss: go to IDLE.
//  Registered outputs update the clk after the event, so latency is 1 clk.
//  Priority, highest first: rst > alarm_en=0 > wr_en to this slot > dismiss > snooze > tick.
//   - A wr_en to a slot forces that channel to IDLE in the same cycle; no trigger in that cycle.
//   - dismiss and snooze together: dismiss wins.
//   - snooze and tick together: the snooze counter loads the full reload value, with no
//     decrement that cycle.
//   - A tick on the timeout cycle together with snooze: snooze wins, and missed is not set.
//  Writing arm=0 to a ringing slot stops it; missed is unaffected.
//   - missed_clr and a new missed in the same cycle: set wins.
//  alarm_led: a toggle flop flips on each tick while any_ring. It is held 0 and reset to 0 when
//   !any_ring.
//  BCD values are not range-checked; comparison is a bitwise 16-bit equality.
//  Counter widths are $clog2(SNOOZE_MIN*60+1), $clog2(RING_TO_S+1) and $clog2(SNOOZE_MAX+1).
//  N_ALARMS=1: ring_idx is a 1-bit value, always 0.
// TESTING
//  1 Arm slot2=12:30; cur_time=16'h1230, cur_sec=00, tick -> ringing=4'b0100, ring_idx=2, any_ring.
//  2 While ringing, snooze -> snoozed[2]. After 300 ticks -> ringing[2] again; a 4th snooze -> IDLE, missed[2]=0.
//  3 Ring, no action for 60 ticks -> IDLE, missed[2]=1; missed_clr -> missed=0.
//  4 Slots 0 and 3 both 07:00, fire together -> ringing=4'b1001, ring_idx=0; dismiss -> all 0.
//  5 cur_time matches with cur_sec=8'h01 -> no ring. With alarm_en=0 -> no ring; dropping alarm_en mid-ring -> IDLE.
//  6 rst asserted mid-SNOOZED -> all outputs 0, slots 0; wr_en to a ringing slot same cycle as dismiss -> IDLE.

Source files
------------

// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl
//   N-channel alarm controller for the digital clock. Each slot stores a BCD
//   HH:MM time and an arm bit. A channel starts ringing on the 1 Hz tick at
//   second 00 of a matching minute. It can then be snoozed a limited number of
//   times or dismissed. If nobody answers it, it times out and sets a sticky
//   missed flag. A shared LED blinks while any channel rings.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   tick_1hz          one-clk pulse per second
//   cur_time, cur_sec running BCD time {HH,MM} and seconds
//   alarm_en          global enable; low forces every channel idle
//   wr_en/wr_idx/     program one slot (time + arm); also forces that
//   wr_time/wr_arm    channel idle
//   dismiss, snooze,  one-clk button pulses acting on all channels
//   missed_clr
//   rd_idx/rd_time/   combinational slot readback
//   rd_arm
//   ringing, snoozed, per-channel status (registered state)
//   missed
//   any_ring,         summary of ringing, lowest ringing index,
//   ring_idx,         0.5 Hz blink while ringing
//   alarm_led
module multi_alarm_ctrl #(
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int SNOOZE_MAX = 3,
    parameter int RING_TO_S  = 60,
    localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1hz,
    input  logic [15:0]         cur_time,
    input  logic [7:0]          cur_sec,
    input  logic                alarm_en,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [15:0]         wr_time,
    input  logic                wr_arm,
    input  logic                dismiss,
    input  logic                snooze,
    input  logic                missed_clr,
    input  logic [IW-1:0]       rd_idx,
    output logic [15:0]         rd_time,
    output logic                rd_arm,
    output logic [N_ALARMS-1:0] ringing,
    output logic [N_ALARMS-1:0] snoozed,
    output logic [N_ALARMS-1:0] missed,
    output logic                any_ring,
    output logic [IW-1:0]       ring_idx,
    output logic                alarm_led
);

    localparam int RELOAD = SNOOZE_MIN * 60;
    localparam int SW = ($clog2(RELOAD + 1)    > 0) ? $clog2(RELOAD + 1)    : 1;
    localparam int RW = ($clog2(RING_TO_S + 1) > 0) ? $clog2(RING_TO_S + 1) : 1;
    localparam int UW = ($clog2(SNOOZE_MAX + 1) > 0) ? $clog2(SNOOZE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } ch_state_t;

    logic [15:0]         slot_time [N_ALARMS];
    logic [N_ALARMS-1:0] slot_arm;
    logic [N_ALARMS-1:0] wr_sel;

    for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
        ch_state_t     state;
        logic [RW-1:0] ring_cnt;
        logic [SW-1:0] snz_cnt;
        logic [UW-1:0] uses;
        logic          miss;
        logic          match;
        logic          timeout;

        assign wr_sel[g] = wr_en && (wr_idx == IW'(g));

        // Trigger uses the slot contents from before any write this cycle;
        // a write to this slot overrides the trigger anyway.
        assign match = tick_1hz && slot_arm[g] && (cur_time == slot_time[g])
                       && (cur_sec == 8'h00);

        // A timeout only counts when nothing of higher priority acts on the
        // channel this cycle, so a snooze on the timeout tick suppresses missed.
        assign timeout = alarm_en && !wr_sel[g] && !dismiss && !snooze
                         && tick_1hz && (state == RINGING)
                         && (ring_cnt == RW'(RING_TO_S - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_time[g] <= 16'h0000;
                slot_arm[g]  <= 1'b0;
            end else if (wr_sel[g]) begin
                slot_time[g] <= wr_time;
                slot_arm[g]  <= wr_arm;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= IDLE;
                ring_cnt <= '0;
                snz_cnt  <= '0;
                uses     <= '0;
            end else if (!alarm_en || wr_sel[g]) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (match) begin
                            state    <= RINGING;
                            ring_cnt <= '0;
                            uses     <= '0;
                        end
                    end
                    RINGING: begin
                        if (dismiss) begin
                            state <= IDLE;
                        end else if (snooze) begin
                            // Out of snoozes: the press behaves like dismiss.
                            if (uses < UW'(SNOOZE_MAX)) begin
                                state   <= SNOOZED;
                                uses    <= uses + 1'b1;
                                snz_cnt <= SW'(RELOAD);
                            end else begin
                                state <= IDLE;
                            end
                        end else if (tick_1hz) begin
                            if (timeout) begin
                                state <= IDLE;
                            end else begin
                                ring_cnt <= ring_cnt + 1'b1;
                            end
                        end
                    end
                    SNOOZED: begin
                        if (dismiss) begin
                            state <= IDLE;
                        end else if (tick_1hz) begin
                            if (snz_cnt <= SW'(1)) begin
                                state    <= RINGING;
                                ring_cnt <= '0;
                                snz_cnt  <= '0;
                            end else begin
                                snz_cnt <= snz_cnt - 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        // Sticky missed flag; a new timeout beats a simultaneous clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                miss <= 1'b0;
            end else if (timeout) begin
                miss <= 1'b1;
            end else if (missed_clr) begin
                miss <= 1'b0;
            end
        end

        assign ringing[g] = (state == RINGING);
        assign snoozed[g] = (state == SNOOZED);
        assign missed[g]  = miss;
    end

    always_comb begin
        rd_time = 16'h0000;
        rd_arm  = 1'b0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_time = slot_time[i];
                rd_arm  = slot_arm[i];
            end
        end
    end

    assign any_ring = |ringing;

    // Scan from the top so the lowest ringing index wins.
    always_comb begin
        ring_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) begin
                ring_idx = IW'(i);
            end
        end
    end

    // Toggles once per second while ringing, giving a 0.5 Hz blink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_led <= 1'b0;
        end else if (!any_ring) begin
            alarm_led <= 1'b0;
        end else if (tick_1hz) begin
            alarm_led <= ~alarm_led;
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Testbench for multi_alarm_ctrl (default parameters: 4 channels, 300-tick
// snooze, 3 snoozes, 60-tick ring timeout).
module tb_multi_alarm_ctrl;

    localparam int N     = 4;
    localparam int SMIN  = 5;
    localparam int SMAX  = 3;
    localparam int RTO   = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0;
    logic [15:0] cur_time = 16'h0000;
    logic [7:0]  cur_sec = 8'h01;
    logic        alarm_en = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = 2'd0;
    logic [15:0] wr_time = 16'h0000;
    logic        wr_arm = 1'b0;
    logic        dismiss = 1'b0;
    logic        snooze = 1'b0;
    logic        missed_clr = 1'b0;
    logic [1:0]  rd_idx = 2'd0;
    logic [15:0] rd_time;
    logic        rd_arm;
    logic [3:0]  ringing, snoozed, missed;
    logic        any_ring;
    logic [1:0]  ring_idx;
    logic        alarm_led;

    int checks = 0;
    int failures = 0;

    multi_alarm_ctrl #(
        .N_ALARMS(N), .SNOOZE_MIN(SMIN), .SNOOZE_MAX(SMAX), .RING_TO_S(RTO)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .cur_time(cur_time),
        .cur_sec(cur_sec), .alarm_en(alarm_en), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_time(wr_time), .wr_arm(wr_arm), .dismiss(dismiss), .snooze(snooze),
        .missed_clr(missed_clr), .rd_idx(rd_idx), .rd_time(rd_time), .rd_arm(rd_arm),
        .ringing(ringing), .snoozed(snoozed), .missed(missed), .any_ring(any_ring),
        .ring_idx(ring_idx), .alarm_led(alarm_led)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (remaining-time view) ----------------
    logic [15:0] m_time [N];
    bit          m_arm [N];
    bit          m_ring [N];
    bit          m_snz [N];
    bit          m_missed [N];
    int          m_ring_left [N];
    int          m_snz_left [N];
    int          m_uses [N];
    bit          m_led;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_time[i] = 16'h0000; m_arm[i] = 0; m_ring[i] = 0; m_snz[i] = 0;
            m_missed[i] = 0; m_ring_left[i] = 0; m_snz_left[i] = 0; m_uses[i] = 0;
        end
        m_led = 0;
    endtask

    task automatic model_step();
        bit old_any;
        bit timed_out;
        old_any = 0;
        for (int i = 0; i < N; i++) old_any |= m_ring[i];
        for (int i = 0; i < N; i++) begin
            timed_out = 0;
            if (!alarm_en || (wr_en && int'(wr_idx) == i)) begin
                m_ring[i] = 0; m_snz[i] = 0;
            end else if (m_ring[i]) begin
                if (dismiss) m_ring[i] = 0;
                else if (snooze) begin
                    m_ring[i] = 0;
                    if (m_uses[i] < SMAX) begin
                        m_snz[i] = 1; m_uses[i]++; m_snz_left[i] = SMIN * 60;
                    end
                end else if (tick_1hz) begin
                    m_ring_left[i]--;
                    if (m_ring_left[i] == 0) begin m_ring[i] = 0; timed_out = 1; end
                end
            end else if (m_snz[i]) begin
                if (dismiss) m_snz[i] = 0;
                else if (tick_1hz) begin
                    m_snz_left[i]--;
                    if (m_snz_left[i] == 0) begin
                        m_snz[i] = 0; m_ring[i] = 1; m_ring_left[i] = RTO;
                    end
                end
            end else if (tick_1hz && m_arm[i] && cur_time == m_time[i] && cur_sec == 8'h00) begin
                m_ring[i] = 1; m_ring_left[i] = RTO; m_uses[i] = 0;
            end
            if (timed_out) m_missed[i] = 1;
            else if (missed_clr) m_missed[i] = 0;
        end
        if (!old_any) m_led = 0;
        else if (tick_1hz) m_led = ~m_led;
        if (wr_en) begin m_time[wr_idx] = wr_time; m_arm[wr_idx] = wr_arm; end
    endtask

    function automatic logic [63:0] model_vec();
        logic [3:0] r, s, ms;
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N - 1; i >= 0; i--) begin
            r[i] = m_ring[i]; s[i] = m_snz[i]; ms[i] = m_missed[i];
            if (m_ring[i]) idx = 2'(i);
        end
        return {31'b0, r, s, ms, idx, |r, m_led, m_time[rd_idx], m_arm[rd_idx]};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {31'b0, ringing, snoozed, missed, ring_idx, any_ring, alarm_led, rd_time, rd_arm};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model, let the edge pass, sample 1 time unit later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        tick_1hz = 0; wr_en = 0; dismiss = 0; snooze = 0; missed_clr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick_1hz = 0; wr_en = 0; dismiss = 0; snooze = 0; missed_clr = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cur_sec = 8'h01;
            tick_1hz = 1;
            cycle();
        end
    endtask

    task automatic trig();
        cur_sec = 8'h00; tick_1hz = 1;
        cycle();
        cur_sec = 8'h01;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          we;
        logic [1:0]  wi;
        logic [15:0] wt;
        bit          wa;
        bit          ae;
        bit          tk;
        logic [15:0] ct;
        logic [7:0]  cs;
        bit          dm;
        bit          sn;
        logic [3:0]  er;
        logic [1:0]  ei;
        bit          el;
    } vec_t;

    function automatic vec_t mkv(bit we, logic [1:0] wi, logic [15:0] wt, bit wa, bit ae,
                                 bit tk, logic [15:0] ct, logic [7:0] cs, bit dm, bit sn,
                                 logic [3:0] er, logic [1:0] ei, bit el);
        vec_t v;
        v.we = we; v.wi = wi; v.wt = wt; v.wa = wa; v.ae = ae; v.tk = tk; v.ct = ct;
        v.cs = cs; v.dm = dm; v.sn = sn; v.er = er; v.ei = ei; v.el = el;
        return v;
    endfunction

    vec_t tbl [20];
    logic [15:0] rd_exp_time [4];
    logic        rd_exp_arm [4];
    logic [15:0] times [3];

    initial begin
        tbl[0]  = mkv(1, 2, 16'h1230, 1, 1, 0, 16'h1230, 8'h00, 0, 0, 4'b0000, 0, 0);
        tbl[1]  = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h1230, 8'h01, 0, 0, 4'b0000, 0, 0);
        tbl[2]  = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h1230, 8'h00, 0, 0, 4'b0100, 2, 0);
        tbl[3]  = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h1230, 8'h00, 0, 0, 4'b0100, 2, 1);
        tbl[4]  = mkv(0, 0, 16'h0000, 0, 1, 0, 16'h1230, 8'h00, 0, 0, 4'b0100, 2, 1);
        tbl[5]  = mkv(0, 0, 16'h0000, 0, 1, 0, 16'h1230, 8'h01, 1, 0, 4'b0000, 0, 1);
        tbl[6]  = mkv(0, 0, 16'h0000, 0, 1, 0, 16'h1230, 8'h01, 0, 0, 4'b0000, 0, 0);
        tbl[7]  = mkv(1, 0, 16'h0700, 1, 1, 0, 16'h1230, 8'h01, 0, 0, 4'b0000, 0, 0);
        tbl[8]  = mkv(1, 3, 16'h0700, 1, 1, 0, 16'h1230, 8'h01, 0, 0, 4'b0000, 0, 0);
        tbl[9]  = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h0700, 8'h00, 0, 0, 4'b1001, 0, 0);
        tbl[10] = mkv(0, 0, 16'h0000, 0, 1, 0, 16'h0700, 8'h01, 1, 1, 4'b0000, 0, 0);
        tbl[11] = mkv(0, 0, 16'h0000, 0, 0, 1, 16'h0700, 8'h00, 0, 0, 4'b0000, 0, 0);
        tbl[12] = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h0700, 8'h00, 0, 0, 4'b1001, 0, 0);
        tbl[13] = mkv(0, 0, 16'h0000, 0, 0, 0, 16'h0700, 8'h01, 0, 0, 4'b0000, 0, 0);
        tbl[14] = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h0700, 8'h00, 0, 0, 4'b1001, 0, 0);
        tbl[15] = mkv(1, 3, 16'h0700, 0, 1, 0, 16'h0700, 8'h01, 1, 0, 4'b0000, 0, 0);
        tbl[16] = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h0700, 8'h00, 0, 0, 4'b0001, 0, 0);
        tbl[17] = mkv(0, 0, 16'h0000, 0, 1, 1, 16'h0701, 8'h00, 0, 0, 4'b0001, 0, 1);
        tbl[18] = mkv(1, 0, 16'h0700, 0, 1, 0, 16'h0701, 8'h00, 0, 0, 4'b0000, 0, 1);
        tbl[19] = mkv(0, 0, 16'h0000, 0, 1, 0, 16'h0701, 8'h00, 0, 0, 4'b0000, 0, 0);
        rd_exp_time[0] = 16'h0700; rd_exp_arm[0] = 0;
        rd_exp_time[1] = 16'h0000; rd_exp_arm[1] = 0;
        rd_exp_time[2] = 16'h1230; rd_exp_arm[2] = 1;
        rd_exp_time[3] = 16'h0700; rd_exp_arm[3] = 0;
        times[0] = 16'h0700; times[1] = 16'h1230; times[2] = 16'h2359;

        // ---- reset state ----
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            chk($sformatf("reset_state%0d", i), dut_vec(), 64'h0);
        end
        rst = 0;
        rd_idx = 2'd0;

        // ---- table-driven single-cycle vectors ----
        for (int v = 0; v < 20; v++) begin
            wr_en = tbl[v].we; wr_idx = tbl[v].wi; wr_time = tbl[v].wt; wr_arm = tbl[v].wa;
            alarm_en = tbl[v].ae; tick_1hz = tbl[v].tk; cur_time = tbl[v].ct;
            cur_sec = tbl[v].cs; dismiss = tbl[v].dm; snooze = tbl[v].sn;
            cycle();
            chk($sformatf("vec%0d", v),
                {ringing, snoozed, missed, ring_idx, any_ring, alarm_led},
                {tbl[v].er, 4'b0000, 4'b0000, tbl[v].ei, |tbl[v].er, tbl[v].el});
        end
        alarm_en = 1;
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            chk($sformatf("readback%0d", i), {rd_time, rd_arm}, {rd_exp_time[i], rd_exp_arm[i]});
        end

        // ---- snooze sequence: three snoozes then a fourth acts as dismiss ----
        do_reset();
        cur_time = 16'h1230;
        wr_en = 1; wr_idx = 2; wr_time = 16'h1230; wr_arm = 1;
        cycle();
        trig();
        chk("snz_ring", {ringing, ring_idx, any_ring}, {4'b0100, 2'd2, 1'b1});
        snooze = 1; cycle();
        chk("snz1", {ringing, snoozed}, {4'b0000, 4'b0100});
        ticks(299);
        chk("snz1_299", {ringing, snoozed}, {4'b0000, 4'b0100});
        ticks(1);
        chk("snz1_300", {ringing, snoozed}, {4'b0100, 4'b0000});
        snooze = 1; tick_1hz = 1; cycle();
        chk("snz2_tick", {ringing, snoozed}, {4'b0000, 4'b0100});
        ticks(299);
        chk("snz2_reload", {ringing, snoozed}, {4'b0000, 4'b0100});
        ticks(1);
        chk("snz2_300", {ringing, snoozed}, {4'b0100, 4'b0000});
        snooze = 1; cycle();
        ticks(300);
        chk("snz3_300", {ringing, snoozed}, {4'b0100, 4'b0000});
        snooze = 1; cycle();
        chk("snz4_dismiss", {ringing, snoozed, missed}, {4'b0000, 4'b0000, 4'b0000});

        // ---- snooze on the timeout tick ----
        trig();
        ticks(59);
        chk("to_snz_pre", ringing, 4'b0100);
        snooze = 1; tick_1hz = 1; cycle();
        chk("to_snz", {ringing, snoozed, missed}, {4'b0000, 4'b0100, 4'b0000});
        dismiss = 1; cycle();
        chk("snz_dismiss", {ringing, snoozed}, {4'b0000, 4'b0000});

        // ---- timeout sets missed; clear; set beats clear ----
        trig();
        ticks(59);
        chk("to_59", {ringing, missed}, {4'b0100, 4'b0000});
        ticks(1);
        chk("to_60", {ringing, missed, any_ring}, {4'b0000, 4'b0100, 1'b0});
        missed_clr = 1; cycle();
        chk("missed_clr", missed, 4'b0000);
        trig();
        ticks(59);
        tick_1hz = 1; missed_clr = 1; cycle();
        chk("missed_set_wins", missed, 4'b0100);
        missed_clr = 1; cycle();
        chk("missed_clr2", missed, 4'b0000);

        // ---- asynchronous reset while snoozed ----
        trig();
        snooze = 1; cycle();
        chk("pre_rst_snz", snoozed, 4'b0100);
        rd_idx = 2;
        rst = 1;
        #1;
        chk("async_rst", dut_vec(), 64'h0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();

        // ---- randomized run against the reference model ----
        for (int c = 0; c < 6000; c++) begin
            alarm_en   = ($urandom_range(0, 199) != 0);
            tick_1hz   = 1'($urandom_range(0, 1));
            cur_time   = times[$urandom_range(0, 2)];
            cur_sec    = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'h30;
            wr_en      = ($urandom_range(0, 49) == 0);
            wr_idx     = 2'($urandom_range(0, 3));
            wr_time    = times[$urandom_range(0, 2)];
            wr_arm     = ($urandom_range(0, 3) != 0);
            dismiss    = ($urandom_range(0, 149) == 0);
            snooze     = ($urandom_range(0, 59) == 0);
            missed_clr = ($urandom_range(0, 79) == 0);
            rd_idx     = 2'($urandom_range(0, 3));
            cycle();
            chk($sformatf("rand%0d", c), dut_vec(), model_vec());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
